// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage memory access unit.
// Holds the access FSM state encoding, M-bit positions and the timeout fill word.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int M_READ_BIT  = 1;
    localparam int M_WRITE_BIT = 0;

    localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with bubble insertion while the MEM stage stalls.
// Ports: clk/rst_n, stall, squash, *_next inputs from MEM, registered wb/alu/rd/data.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        squash,
    input  logic [1:0]  wb_next,
    input  logic [31:0] alu_next,
    input  logic [4:0]  rd_next,
    input  logic [31:0] data_next,
    output logic [1:0]  wb,
    output logic [31:0] alu,
    output logic [4:0]  rd,
    output logic [31:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb   <= '0;
            alu  <= '0;
            rd   <= '0;
            data <= '0;
        end else if (stall) begin
            // Bubble: kill writeback, keep the datapath fields.
            wb <= '0;
        end else begin
            wb   <= squash ? 2'b00 : wb_next;
            alu  <= alu_next;
            rd   <= rd_next;
            data <= data_next;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives a req/ack data-memory port from MemRead/MemWrite, stalls
// upstream while busy, loads MEM/WB and flags misaligned/illegal/timeout.
// Ports: Clock_i/Rst_n_i, EX/MEM inputs, Stall_o, mem_* port, MEM/WB outputs, error flags.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
)
(
    input  logic        Clock_i,
    input  logic        Rst_n_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] ALU_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  RegRd_i,
    output logic        Stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  WB_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALU_o,
    output logic [4:0]  RegRd_o,
    output logic        AlignErr_o,
    output logic        IllegalErr_o,
    output logic        TimeoutErr_o
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cap;

    logic rd_op;
    logic wr_op;
    logic idle;
    logic access;
    logic misalign;
    logic illegal;
    logic timeout_hit;
    logic [31:0] load_data;

    assign rd_op    = M_i[M_READ_BIT] & ~M_i[M_WRITE_BIT];
    assign wr_op    = M_i[M_WRITE_BIT] & ~M_i[M_READ_BIT];
    assign idle     = (state == IDLE);
    // Only decode in IDLE: in BUSY/DONE the inputs are the held instruction.
    assign access   = idle & (rd_op | wr_op) & (ALU_i[1:0] == 2'b00);
    assign misalign = idle & (rd_op | wr_op) & (ALU_i[1:0] != 2'b00);
    assign illegal  = idle & (M_i == 2'b11);

    assign Stall_o     = access | (state == BUSY);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign load_data   = ((state == DONE) && !mem_we_o) ? cap : 32'h0;

    always_ff @(posedge Clock_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state        <= IDLE;
            cnt          <= '0;
            cap          <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            AlignErr_o   <= 1'b0;
            IllegalErr_o <= 1'b0;
            TimeoutErr_o <= 1'b0;
        end else begin
            AlignErr_o   <= misalign;
            IllegalErr_o <= illegal;
            unique case (state)
                IDLE: begin
                    if (access) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= wr_op;
                        mem_addr_o  <= ALU_i;
                        mem_wdata_o <= WriteData_i;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // Ack wins over a coincident timeout compare.
                    if (mem_ack_i) begin
                        if (!mem_we_o) cap <= mem_rdata_i;
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        mem_req_o    <= 1'b0;
                        cap          <= TIMEOUT_FILL;
                        TimeoutErr_o <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb (
        .clk       (Clock_i),
        .rst_n     (Rst_n_i),
        .stall     (Stall_o),
        .squash    (misalign | illegal),
        .wb_next   (WB_i),
        .alu_next  (ALU_i),
        .rd_next   (RegRd_i),
        .data_next (load_data),
        .wb        (WB_o),
        .alu       (ALU_o),
        .rd        (RegRd_o),
        .data      (ReadData_o)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset corner case,
// and randomized instruction stream checked against a transaction-level model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        Clock_i = 1'b0;
    logic        Rst_n_i;
    logic [1:0]  WB_i;
    logic [1:0]  M_i;
    logic [31:0] ALU_i;
    logic [31:0] WriteData_i;
    logic [4:0]  RegRd_i;
    logic        Stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  WB_o;
    logic [31:0] ReadData_o;
    logic [31:0] ALU_o;
    logic [4:0]  RegRd_o;
    logic        AlignErr_o;
    logic        IllegalErr_o;
    logic        TimeoutErr_o;

    always #5 Clock_i = ~Clock_i;

    mem_access_unit #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16)
    ) dut (
        .Clock_i      (Clock_i),
        .Rst_n_i      (Rst_n_i),
        .WB_i         (WB_i),
        .M_i          (M_i),
        .ALU_i        (ALU_i),
        .WriteData_i  (WriteData_i),
        .RegRd_i      (RegRd_i),
        .Stall_o      (Stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .WB_o         (WB_o),
        .ReadData_o   (ReadData_o),
        .ALU_o        (ALU_o),
        .RegRd_o      (RegRd_o),
        .AlignErr_o   (AlignErr_o),
        .IllegalErr_o (IllegalErr_o),
        .TimeoutErr_o (TimeoutErr_o)
    );

    typedef struct {
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          waits;
        logic [31:0] rdat;
        int          e_stall;
        int          e_req;
        logic [1:0]  e_wb;
        logic [31:0] e_rdata;
        logic        e_align;
        logic        e_ill;
        logic        e_tmo;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    bit tmo_sticky;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents one instruction, plays memory, and checks the MEM/WB result.
    task automatic run_instr(input vec_t v);
        int   stalls = 0;
        int   reqs = 0;
        bit   bub_ok = 1'b1;
        bit   port_ok = 1'b1;
        bit   done = 1'b0;
        logic st;
        WB_i        = v.wb;
        M_i         = v.m;
        ALU_i       = v.alu;
        WriteData_i = v.wd;
        RegRd_i     = v.rd;
        for (int c = 0; c < TMO + 10; c++) begin
            if (mem_req_o) begin
                if (mem_we_o !== (v.m == 2'b01) || mem_addr_o !== v.alu ||
                    (v.m == 2'b01 && mem_wdata_o !== v.wd))
                    port_ok = 1'b0;
                mem_ack_i   = (reqs == v.waits);
                mem_rdata_i = mem_ack_i ? v.rdat : $urandom;
                reqs++;
            end else begin
                mem_ack_i   = 1'($urandom_range(0, 1));
                mem_rdata_i = $urandom;
            end
            #1;
            st = Stall_o;
            @(posedge Clock_i);
            #1;
            if (st) begin
                stalls++;
                if (WB_o !== 2'b00) bub_ok = 1'b0;
            end else begin
                done = 1'b1;
                break;
            end
        end
        mem_ack_i = 1'b0;
        chk("complete", 32'(done), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(v.e_stall));
        chk("req_cycles", 32'(reqs), 32'(v.e_req));
        chk("bubble", 32'(bub_ok), 32'd1);
        chk("port_stable", 32'(port_ok), 32'd1);
        chk("wb_o", 32'(WB_o), 32'(v.e_wb));
        chk("readdata_o", ReadData_o, v.e_rdata);
        chk("alu_o", ALU_o, v.alu);
        chk("regrd_o", 32'(RegRd_o), 32'(v.rd));
        chk("align_err", 32'(AlignErr_o), 32'(v.e_align));
        chk("illegal_err", 32'(IllegalErr_o), 32'(v.e_ill));
        chk("timeout_err", 32'(TimeoutErr_o), 32'(v.e_tmo));
    endtask

    initial begin
        Rst_n_i     = 1'b0;
        WB_i        = '0;
        M_i         = '0;
        ALU_i       = '0;
        WriteData_i = '0;
        RegRd_i     = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        tmo_sticky  = 1'b0;

        // wb, m, alu, wd, rd, waits, rdat | stall, req, wb, rdata, align, ill, tmo
        tbl[0] = '{2'b11, 2'b10, 32'h10, 32'h0, 5'd5, 2, 32'h12345678,
                   4, 3, 2'b11, 32'h12345678, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b10, 2'b01, 32'h20, 32'hCAFEF00D, 5'd7, 0, 32'h0,
                   2, 1, 2'b10, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b11, 2'b10, 32'h13, 32'h0, 5'd9, 0, 32'h0,
                   0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{2'b01, 2'b00, 32'h55, 32'h0, 5'd3, 0, 32'h0,
                   0, 0, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'b11, 2'b11, 32'h40, 32'h0, 5'd4, 0, 32'h0,
                   0, 0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{2'b11, 2'b10, 32'h24, 32'h0, 5'd11, 3, 32'hA5A5C3C3,
                   5, 4, 2'b11, 32'hA5A5C3C3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{2'b01, 2'b10, 32'h28, 32'h0, 5'd12, 0, 32'h11112222,
                   2, 1, 2'b01, 32'h11112222, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'b11, 2'b10, 32'h2C, 32'h0, 5'd13, 99, 32'h0,
                   5, 4, 2'b11, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{2'b11, 2'b01, 32'h22, 32'h77, 5'd14, 0, 32'h0,
                   0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1};

        #12;
        chk("reset_ctrl", 32'({mem_req_o, mem_we_o, WB_o, AlignErr_o,
                               IllegalErr_o, TimeoutErr_o, Stall_o}), 32'd0);
        chk("reset_data", mem_addr_o | mem_wdata_o | ReadData_o | ALU_o |
                          32'(RegRd_o), 32'd0);
        @(negedge Clock_i);
        Rst_n_i = 1'b1;
        @(posedge Clock_i);
        #1;

        for (int i = 0; i < 9; i++) run_instr(tbl[i]);

        // Reset in the middle of BUSY, then a late ack.
        WB_i  = 2'b11;
        M_i   = 2'b10;
        ALU_i = 32'h30;
        RegRd_i = 5'd6;
        mem_ack_i = 1'b0;
        @(posedge Clock_i);
        #1;
        chk("rst_busy_req", 32'(mem_req_o), 32'd1);
        @(posedge Clock_i);
        #2;
        Rst_n_i = 1'b0;
        #1;
        chk("rst_async_req", 32'(mem_req_o), 32'd0);
        M_i  = 2'b00;
        WB_i = 2'b00;
        ALU_i = '0;
        RegRd_i = '0;
        #1;
        chk("rst_ctrl", 32'({mem_req_o, mem_we_o, WB_o, AlignErr_o,
                             IllegalErr_o, TimeoutErr_o, Stall_o}), 32'd0);
        chk("rst_data", mem_addr_o | mem_wdata_o | ReadData_o | ALU_o |
                        32'(RegRd_o), 32'd0);
        @(negedge Clock_i);
        Rst_n_i     = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBAADF00D;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock_i);
            #1;
            chk("late_ack", 32'({mem_req_o, Stall_o, WB_o}) | ReadData_o,
                32'd0);
        end
        mem_ack_i  = 1'b0;
        tmo_sticky = 1'b0;

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int   k;
            bit   rw;
            bit   acc;
            bit   to;
            k = $urandom_range(0, 9);
            v.m = (k < 4) ? 2'b10 : (k < 7) ? 2'b01 : (k < 8) ? 2'b11 : 2'b00;
            v.alu = $urandom;
            if ($urandom_range(0, 3) != 0) v.alu[1:0] = 2'b00;
            v.wd    = $urandom;
            v.wb    = 2'($urandom_range(1, 3));
            v.rd    = 5'($urandom);
            v.waits = $urandom_range(0, TMO + 1);
            v.rdat  = $urandom;
            rw  = (v.m == 2'b10) || (v.m == 2'b01);
            acc = rw && (v.alu[1:0] == 2'b00);
            to  = acc && (v.waits >= TMO);
            v.e_stall = !acc ? 0 : (to ? TMO + 1 : v.waits + 2);
            v.e_req   = !acc ? 0 : (to ? TMO : v.waits + 1);
            v.e_wb    = ((v.m == 2'b11) || (rw && !acc)) ? 2'b00 : v.wb;
            v.e_rdata = (acc && v.m == 2'b10) ?
                        (to ? 32'hDEADBEEF : v.rdat) : 32'h0;
            v.e_align = rw && !acc;
            v.e_ill   = (v.m == 2'b11);
            tmo_sticky = tmo_sticky | to;
            v.e_tmo   = tmo_sticky;
            run_instr(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
